pipe_sched: RTL and testbench
=============================

PIPE_SCHED -- requirements
Module: pipe_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter DELAY, default 3, fixed latency of the external datapath in cycles (>=1).
REQ-003 SHALL have parameter WIDTH, default 16, data width in bits.
REQ-004 SHALL have parameter DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port req, input, NREQ, per-requester request; held until granted.
REQ-008 SHALL have port req_data, input, NREQ*WIDTH, request operands; slice n belongs to req[n].
REQ-009 SHALL have port gnt, output, NREQ, one-hot combinational grant, same cycle as req.
REQ-010 SHALL have port pipe_vld, output, 1, registered issue strobe to the datapath.
REQ-011 SHALL have port pipe_din, output, WIDTH, registered operand to the datapath.
REQ-012 SHALL have port pipe_dout, input, WIDTH, datapath result, valid exactly DELAY cycles after pipe_vld.
REQ-013 SHALL have port o_valid, output, 1, result FIFO not empty.
REQ-014 SHALL have port o_ready, input, 1, consumer accept; pop when o_valid and o_ready.
REQ-015 SHALL have port o_data, output, WIDTH, FIFO head result.
REQ-016 SHALL have port o_tag, output, clog2(NREQ), index of the requester that issued the head result.

Function
REQ-017 SHALL grant at most one requester per cycle, round-robin: priority starts at ptr, ptr = granted index + 1 mod NREQ after each grant.
REQ-018 SHALL grant only when credit > 0; credit = DEPTH - (in-flight count + FIFO occupancy).
REQ-019 SHALL, on a grant to n in cycle t, assert pipe_vld with pipe_din = req_data[n] in cycle t+1 only.
REQ-020 SHALL carry valid and tag through a DELAY-stage shift register cleared by reset, aligned to pipe_dout.
REQ-021 SHALL write {tag, pipe_dout} into the FIFO in cycle t+1+DELAY; o_valid SHALL rise no earlier than t+2+DELAY.
REQ-022 SHALL keep credit unchanged when a grant and a pop occur in the same cycle; SHALL decrement on grant only, increment on pop only.
REQ-023 SHALL never overflow the FIFO; credit accounting SHALL guarantee a free entry for every in-flight result.
REQ-024 SHALL present results in issue order; o_data/o_tag SHALL hold stable while o_valid and not o_ready.
REQ-025 SHALL, with DEPTH credits consumed and o_ready low, deassert all gnt until a pop.
REQ-026 SHALL wrap FIFO read/write pointers modulo DEPTH without losing or duplicating entries.

Reset
REQ-027 SHALL, while reset is high, drive gnt=0, pipe_vld=0, o_valid=0, and clear ptr to 0, credit to DEPTH, FIFO pointers and all delay-stage valids.
REQ-028 SHALL discard in-flight results when reset is asserted mid-operation; no FIFO write SHALL occur for issues made before reset.
REQ-029 SHALL drive pipe_din, o_data and o_tag to 0 during reset.

Configuration
REQ-030 SHALL, when PIPE_SCHED_STALL_CNT_EN is defined, provide output stall_cnt (16 bits): counts cycles with req != 0 and credit == 0, saturating at 0xFFFF, cleared by reset.
REQ-031 SHALL, when PIPE_SCHED_STALL_CNT_EN is undefined, omit stall_cnt and its counter logic entirely.

Verification
REQ-032 SHALL cover: req=4'b0001 held one cycle, req_data[0]=0x1234, o_ready=1, DELAY=3 -> pipe_vld at t+1, o_valid at t+5 with o_data=f(0x1234), o_tag=0.
REQ-033 SHALL cover: req=4'b1111 held continuously, o_ready=1 -> gnt sequence 0,1,2,3,0; tags emerge in the same order.
REQ-034 SHALL cover: req=4'b1111, o_ready=0, DEPTH=4 -> exactly 4 grants then gnt=0; one o_ready pulse -> one further grant.
REQ-035 SHALL cover: reset asserted 2 cycles after a grant -> o_valid stays 0, credit returns to 4, no stray FIFO write.
REQ-036 SHALL cover: grant and pop in the same cycle with credit=1 -> credit stays 1, next grant allowed.
REQ-037 SHALL cover, with PIPE_SCHED_STALL_CNT_EN defined: 10 cycles of req!=0 at credit=0 -> stall_cnt=10.

Source files
------------

// File: rtl/pipe_sched_if.sv
// Bundle of request, datapath-issue and result-FIFO signals for pipe_sched.
// master is the scheduler side, slave is the requester/datapath/consumer side.
interface pipe_sched_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned TW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  pipe_vld;
  logic [WIDTH-1:0]      pipe_din;
  logic [WIDTH-1:0]      pipe_dout;
  logic                  o_valid;
  logic                  o_ready;
  logic [WIDTH-1:0]      o_data;
  logic [TW-1:0]         o_tag;

  modport master (
    input  req, req_data, pipe_dout, o_ready,
    output gnt, pipe_vld, pipe_din, o_valid, o_data, o_tag
  );

  modport slave (
    output req, req_data, pipe_dout, o_ready,
    input  gnt, pipe_vld, pipe_din, o_valid, o_data, o_tag
  );
endinterface

// File: rtl/pipe_sched.sv
// Round-robin, credit-gated issue into a fixed-latency datapath with an in-order result FIFO.
// Optional PIPE_SCHED_STALL_CNT_EN adds a saturating stall_cnt output.
module pipe_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DELAY = 3,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  pipe_sched_if.master bus
`ifdef PIPE_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);

  localparam int unsigned TW = $clog2(NREQ);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [TW-1:0]    ptr_q;
  logic [CW-1:0]    credit_q;
  logic             pipe_vld_q;
  logic [WIDTH-1:0] pipe_din_q;
  logic [TW-1:0]    issue_tag_q;
  logic [DELAY-1:0] vld_sr_q;
  logic [TW-1:0]    tag_sr_q [DELAY];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [TW-1:0]    tag_mem  [DEPTH];

  logic [NREQ-1:0]  gnt_d;
  logic [TW-1:0]    gnt_idx;
  logic [TW-1:0]    cand;
  logic             gnt_any;
  logic [WIDTH-1:0] gnt_data;
  logic             push, pop, fifo_valid;

  // Scan from ptr upward; first asserted request wins.
  always_comb begin
    gnt_d   = '0;
    gnt_idx = '0;
    cand    = '0;
    gnt_any = 1'b0;
    if (!reset && credit_q != '0) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        cand = TW'((32'(ptr_q) + i) % NREQ);
        if (!gnt_any && bus.req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
      gnt_d[gnt_idx] = gnt_any;
    end
    gnt_data = bus.req_data[gnt_idx*WIDTH +: WIDTH];
  end

  assign fifo_valid = (count_q != '0) && !reset;
  assign push       = vld_sr_q[DELAY-1];
  assign pop        = fifo_valid && bus.o_ready;

  assign bus.gnt      = gnt_d;
  assign bus.pipe_vld = pipe_vld_q && !reset;
  assign bus.pipe_din = reset ? '0 : pipe_din_q;
  assign bus.o_valid  = fifo_valid;
  assign bus.o_data   = fifo_valid ? data_mem[rptr_q] : '0;
  assign bus.o_tag    = fifo_valid ? tag_mem[rptr_q] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      credit_q    <= CW'(DEPTH);
      pipe_vld_q  <= 1'b0;
      pipe_din_q  <= '0;
      issue_tag_q <= '0;
      vld_sr_q    <= '0;
      for (int unsigned i = 0; i < DELAY; i++) tag_sr_q[i] <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      if (gnt_any) begin
        ptr_q       <= (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + TW'(1);
        pipe_din_q  <= gnt_data;
        issue_tag_q <= gnt_idx;
      end
      pipe_vld_q <= gnt_any;

      // Valid/tag travel alongside the external datapath so they line up with pipe_dout.
      vld_sr_q[0] <= pipe_vld_q;
      tag_sr_q[0] <= issue_tag_q;
      for (int unsigned i = 1; i < DELAY; i++) begin
        vld_sr_q[i] <= vld_sr_q[i-1];
        tag_sr_q[i] <= tag_sr_q[i-1];
      end

      case ({gnt_any, pop})
        2'b10:   credit_q <= credit_q - CW'(1);
        2'b01:   credit_q <= credit_q + CW'(1);
        default: ;
      endcase

      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      data_mem[wptr_q] <= bus.pipe_dout;
      tag_mem[wptr_q]  <= tag_sr_q[DELAY-1];
    end
  end

`ifdef PIPE_SCHED_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (|bus.req && credit_q == '0 && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_sched.sv
// Randomised and directed bench for pipe_sched against a queue-based transaction model.
module tb_pipe_sched;
  localparam int NREQ  = 4;
  localparam int DELAY = 3;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

`ifdef PIPE_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  pipe_sched #(.NREQ(NREQ), .DELAY(DELAY), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef PIPE_SCHED_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  function automatic logic [WIDTH-1:0] f(input logic [WIDTH-1:0] x);
    return x + 16'h1111;
  endfunction

  // External datapath: DELAY-cycle pipeline applying f.
  logic [WIDTH-1:0] dp [DELAY];
  always @(posedge clk) begin
    dp[0] <= bus.pipe_din;
    for (int k = 1; k < DELAY; k++) dp[k] <= dp[k-1];
  end
  assign bus.pipe_dout = f(dp[DELAY-1]);

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at time %0t", name, got, exp, $time);
  endtask

  // Transaction model: a result is "in flight" from its grant until the cycle it becomes
  // visible (grant cycle + DELAY + 2), then queued in order; credit is whatever space is left.
  typedef struct {
    int               due;
    int               tag;
    logic [WIDTH-1:0] data;
  } ent_t;

  ent_t             infl[$];
  ent_t             fq[$];
  int               m_ptr = 0;
  bit               pend_vld = 0;
  logic [WIDTH-1:0] pend_din = '0;
  int               cyc = 0;
  int               m_stall = 0;
  logic [NREQ-1:0]  last_gnt = '0;

  always @(negedge clk) begin
    int              credit;
    int              gi;
    int              n;
    bit              ev;
    logic [NREQ-1:0] eg;
    cyc++;
    while (infl.size() > 0 && infl[0].due <= cyc) fq.push_back(infl.pop_front());
    credit = DEPTH - infl.size() - fq.size();
    gi = -1;
    eg = '0;
    if (!reset && credit > 0) begin
      for (int k = 0; k < NREQ; k++) begin
        n = (m_ptr + k) % NREQ;
        if (gi < 0 && bus.req[n]) gi = n;
      end
    end
    if (gi >= 0) eg[gi] = 1'b1;
    chk("gnt", bus.gnt, eg);
    chk("pipe_vld", bus.pipe_vld, pend_vld && !reset);
    if (reset) chk("pipe_din_rst", bus.pipe_din, 0);
    else if (pend_vld) chk("pipe_din", bus.pipe_din, pend_din);
    ev = fq.size() > 0 && !reset;
    chk("o_valid", bus.o_valid, ev);
    if (ev) begin
      chk("o_data", bus.o_data, f(fq[0].data));
      chk("o_tag", bus.o_tag, fq[0].tag);
    end else if (reset) begin
      chk("o_data_rst", bus.o_data, 0);
      chk("o_tag_rst", bus.o_tag, 0);
    end
`ifdef PIPE_SCHED_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    last_gnt = eg;
    if (reset) begin
      infl.delete();
      fq.delete();
      m_ptr    = 0;
      pend_vld = 0;
      m_stall  = 0;
    end else begin
      if (gi >= 0) begin
        infl.push_back('{cyc + DELAY + 2, gi, bus.req_data[gi*WIDTH +: WIDTH]});
        m_ptr    = (gi + 1) % NREQ;
        pend_vld = 1;
        pend_din = bus.req_data[gi*WIDTH +: WIDTH];
      end else begin
        pend_vld = 0;
      end
      if (ev && bus.o_ready) void'(fq.pop_front());
      if (bus.req != 0 && credit == 0 && m_stall < 65535) m_stall++;
    end
  end

  task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d,
                       input logic rdy, input logic rst);
    @(posedge clk);
    #1;
    bus.req      = r;
    bus.req_data = d;
    bus.o_ready  = rdy;
    reset        = rst;
  endtask

  task automatic do_reset();
    drive('0, '0, 1'b1, 1'b1);
    drive('0, '0, 1'b1, 1'b1);
  endtask

  localparam logic [NREQ*WIDTH-1:0] DATA4 = 64'h4444_3333_2222_1111;

  initial begin
    int              ng;
    int              nt;
    int              seq[5];
    logic [NREQ-1:0] onehot;
    logic [NREQ-1:0] r;
    logic [NREQ*WIDTH-1:0] d;
    logic            rdy;
    int              rdy_pct;

    bus.req      = '0;
    bus.req_data = '0;
    bus.o_ready  = 1'b1;
    seq = '{0, 1, 2, 3, 0};

    // Reset state and single issue with fixed latency.
    do_reset();
    drive('0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst_gnt_idle", bus.gnt, 0);
    chk("rst_o_valid", bus.o_valid, 0);
    drive(4'b0001, 64'h0000_0000_0000_1234, 1'b1, 1'b0);
    @(negedge clk);
    chk("single_gnt", bus.gnt, 4'b0001);
    drive('0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("single_pipe_vld", bus.pipe_vld, 1);
    chk("single_pipe_din", bus.pipe_din, 16'h1234);
    repeat (3) begin
      drive('0, '0, 1'b1, 1'b0);
      @(negedge clk);
      chk("single_early_valid", bus.o_valid, 0);
    end
    drive('0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("single_o_valid", bus.o_valid, 1);
    chk("single_o_data", bus.o_data, 16'h2345);
    chk("single_o_tag", bus.o_tag, 0);

    // Round-robin order and in-order tags.
    do_reset();
    ng = 0;
    nt = 0;
    for (int c = 0; c < 60 && (ng < 5 || nt < 5); c++) begin
      drive(4'b1111, DATA4, 1'b1, 1'b0);
      @(negedge clk);
      if (|bus.gnt && ng < 5) begin
        onehot = 4'b0001 << seq[ng];
        chk("rr_gnt_seq", bus.gnt, onehot);
        ng++;
      end
      if (bus.o_valid && nt < 5) begin
        chk("rr_tag_seq", bus.o_tag, seq[nt]);
        nt++;
      end
    end
    if (ng < 5 || nt < 5) chk("rr_timeout", ng + nt, 10);

    // Credit exhaustion with consumer stalled, then one pop frees exactly one grant.
    do_reset();
    ng = 0;
    repeat (20) begin
      drive(4'b1111, DATA4, 1'b0, 1'b0);
      @(negedge clk);
      if (|bus.gnt) ng++;
    end
    chk("full_grants", ng, 4);
    chk("full_gnt_zero", bus.gnt, 0);
    drive(4'b1111, DATA4, 1'b1, 1'b0);
    @(negedge clk);
    chk("full_pop_valid", bus.o_valid, 1);
    ng = 0;
    repeat (10) begin
      drive(4'b1111, DATA4, 1'b0, 1'b0);
      @(negedge clk);
      if (|bus.gnt) ng++;
    end
    chk("full_one_more", ng, 1);

    // Reset two cycles after a grant discards the in-flight result and restores credit.
    do_reset();
    drive(4'b0001, DATA4, 1'b1, 1'b0);
    drive('0, DATA4, 1'b1, 1'b0);
    drive('0, DATA4, 1'b1, 1'b1);
    drive('0, DATA4, 1'b1, 1'b1);
    repeat (10) begin
      drive('0, DATA4, 1'b1, 1'b0);
      @(negedge clk);
      chk("midrst_no_valid", bus.o_valid, 0);
    end
    ng = 0;
    repeat (12) begin
      drive(4'b1111, DATA4, 1'b0, 1'b0);
      @(negedge clk);
      if (|bus.gnt) ng++;
    end
    chk("midrst_credit", ng, 4);

    // Grant and pop in the same cycle at credit 1.
    do_reset();
    repeat (3) drive(4'b1111, DATA4, 1'b0, 1'b0);
    repeat (2) drive('0, DATA4, 1'b0, 1'b0);
    drive(4'b0001, DATA4, 1'b1, 1'b0);
    @(negedge clk);
    chk("c1_pop_valid", bus.o_valid, 1);
    chk("c1_gnt_pop", bus.gnt, 4'b0001);
    drive(4'b0001, DATA4, 1'b0, 1'b0);
    @(negedge clk);
    chk("c1_gnt_after", bus.gnt, 4'b0001);
    drive(4'b0001, DATA4, 1'b0, 1'b0);
    @(negedge clk);
    chk("c1_gnt_exhausted", bus.gnt, 0);

`ifdef PIPE_SCHED_STALL_CNT_EN
    do_reset();
    repeat (14) drive(4'b1111, DATA4, 1'b0, 1'b0);
    drive('0, DATA4, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall_ten", stall_cnt, 10);
`endif

    // Random traffic: requests held until granted, varying back-pressure, rare resets.
    do_reset();
    d = '0;
    r = '0;
    rdy_pct = 80;
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) rdy_pct = $urandom_range(10, 100);
      r = bus.req & ~last_gnt;
      for (int k = 0; k < NREQ; k++) begin
        if (!r[k] && $urandom_range(0, 2) == 0) begin
          r[k] = 1'b1;
          d[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
      rdy = $urandom_range(1, 100) <= rdy_pct;
      drive(r, d, rdy, $urandom_range(0, 299) == 0);
    end
    repeat (20) drive('0, d, 1'b1, 1'b0);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
endmodule
